// File: rtl/l2_pkg.sv
// Shared constants for the L2 I-cache fill responder: line geometry, op codes, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package l2_pkg;

    localparam int LINE_W     = 512;
    localparam int LINE_OFF_W = 6;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // FSM encoding, kept as plain constants so older blocks can share it
    typedef logic [1:0] l2_state_t;
    localparam l2_state_t ST_IDLE = 2'd0;
    localparam l2_state_t ST_REQ  = 2'd1;
    localparam l2_state_t ST_RESP = 2'd2;
    localparam l2_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/l2_line_buf.sv
// Single-entry buffer of the last read-completed line: tag compare, storage, write-through update.
// Latency: hit is combinational on lookup_tag; fills and updates land on the next clk edge.
// Backpressure: none, always accepts fill/update; only the valid bit is reset.
module l2_line_buf
    import l2_pkg::*;
#(
    parameter int TAG_W = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [LINE_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] data_q;

    assign hit      = valid_q && (tag_q == lookup_tag);
    assign hit_data = data_q;

    // Valid bit: set by a read fill, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
        end
    end

    // Tag and line storage; a write to the buffered line keeps the copy coherent
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end else if (wr_en && valid_q && (tag_q == wr_tag)) begin
            data_q <= wr_data;
        end
    end

endmodule

// File: rtl/l2_icache_fill_resp.sv
// L2 responder for the I-cache miss port: splits one 512-bit line read/write into single-beat backend transactions.
// Latency: read ack at t0+2*NBEATS+1, write ack at t0+NBEATS+1 (zero-wait backend); +1 per gnt wait or extra rvalid delay.
// Backpressure: one line in flight, mem_req held stable until mem_gnt, one beat outstanding; requester holds I_cache_req until ack.
// Optional L2_RESP_LINEBUF_EN: keeps the last read line so a repeat read acks at t0+1 with no backend traffic.
module l2_icache_fill_resp
    import l2_pkg::*;
#(
    parameter int BEAT_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_cache_req,
    input  logic              I_cache_req_op,
    input  logic [ADDR_W-1:0] I_cache_req_addr,
    input  logic [LINE_W-1:0] I_cache_wr_data,
    output logic              L2_cache_ack,
    output logic [LINE_W-1:0] I_cache_rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata
);

    localparam int NBEATS     = LINE_W / BEAT_W;
    localparam int IDX_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int TAG_W      = ADDR_W - LINE_OFF_W;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NBEATS - 1);

    l2_state_t           state;
    logic                op_q;
    logic [TAG_W-1:0]    tag_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [IDX_W-1:0]    beat_idx;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   line_nxt;
    logic [LINE_OFF_W-1:0] beat_off;
    logic                in_req;
    logic                last_beat;
    logic                take_hit;
    logic [LINE_W-1:0]   hit_line;

    // Byte offsets inside the line are implied by beat_idx, never taken from the requester
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^I_cache_req_addr[LINE_OFF_W-1:0];

    assign in_req    = (state == ST_REQ);
    assign last_beat = (beat_idx == LAST_BEAT);
    assign beat_off  = LINE_OFF_W'(beat_idx * BEAT_BYTES);

    // Backend beat outputs are driven only while a beat is being offered
    assign mem_req      = in_req;
    assign mem_we       = in_req && (op_q == OP_WR);
    assign mem_addr     = in_req ? {tag_q, beat_off} : '0;
    assign mem_wdata    = in_req ? wdata_q[beat_idx*BEAT_W +: BEAT_W] : '0;
    assign L2_cache_ack = (state == ST_DONE);

`ifdef L2_RESP_LINEBUF_EN
    logic lb_hit;
    logic lb_fill_en;
    logic lb_wr_en;

    assign lb_fill_en = (state == ST_DONE) && (op_q == OP_RD);
    assign lb_wr_en   = (state == ST_DONE) && (op_q == OP_WR);

    l2_line_buf #(
        .TAG_W (TAG_W)
    ) u_line_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (I_cache_req_addr[ADDR_W-1:LINE_OFF_W]),
        .hit        (lb_hit),
        .hit_data   (hit_line),
        .fill_en    (lb_fill_en),
        .fill_tag   (tag_q),
        .fill_data  (I_cache_rd_data),
        .wr_en      (lb_wr_en),
        .wr_tag     (tag_q),
        .wr_data    (wdata_q)
    );

    assign take_hit = lb_hit && (I_cache_req_op == OP_RD);
`else
    assign take_hit = 1'b0;
    assign hit_line = '0;
`endif

    // Merge the returning beat into its slice of the partially assembled line
    always_comb begin
        line_nxt = line_q;
        line_nxt[beat_idx*BEAT_W +: BEAT_W] = mem_rdata;
    end

    // Line FSM: capture in IDLE, one beat per REQ(/RESP) pass, one-cycle ack in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            op_q            <= OP_RD;
            tag_q           <= '0;
            wdata_q         <= '0;
            beat_idx        <= '0;
            line_q          <= '0;
            I_cache_rd_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_cache_req) begin
                        op_q     <= I_cache_req_op;
                        tag_q    <= I_cache_req_addr[ADDR_W-1:LINE_OFF_W];
                        wdata_q  <= I_cache_wr_data;
                        beat_idx <= '0;
                        line_q   <= '0;
                        if (take_hit) begin
                            I_cache_rd_data <= hit_line;
                            state           <= ST_DONE;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        if (op_q == OP_RD) begin
                            state <= ST_RESP;
                        end else if (last_beat) begin
                            state <= ST_DONE;
                        end else begin
                            beat_idx <= beat_idx + IDX_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (mem_rvalid) begin
                        line_q <= line_nxt;
                        if (last_beat) begin
                            I_cache_rd_data <= line_nxt;
                            state           <= ST_DONE;
                        end else begin
                            beat_idx <= beat_idx + IDX_W'(1);
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    // Request deliberately not sampled here; IDLE sees it one cycle later
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_icache_fill_resp.sv
module tb_l2_icache_fill_resp;

    localparam logic [511:0] LINE_A = {128'h3333_3333_3333_3333_3333_3333_3333_3333,
                                       128'h2222_2222_2222_2222_2222_2222_2222_2222,
                                       128'h1111_1111_1111_1111_1111_1111_1111_1111,
                                       128'h0000_0000_0000_0000_0000_0000_0000_0000};
    localparam logic [511:0] LINE_B = {128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC,
                                       128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD,
                                       128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE,
                                       128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    localparam logic [127:0] WR_BASE  = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A500;
    localparam logic [127:0] WR2_BASE = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A00;
    localparam logic [127:0] JUNK     = {4{32'hDEAD_BEEF}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         I_cache_req = 1'b0;
    logic         I_cache_req_op = 1'b0;
    logic [31:0]  I_cache_req_addr = '0;
    logic [511:0] I_cache_wr_data = '0;
    logic         L2_cache_ack;
    logic [511:0] I_cache_rd_data;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [127:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    // backend model knobs and log
    int           gnt_cnt = 0;
    int           req_cyc = 0;
    int           dly_idx = -1;
    int           dly = 0;
    int           rv_dly = 0;
    int           wait_cnt = 0;
    int           pend_cnt = 0;
    bit           pend = 1'b0;
    bit           prev_wait = 1'b0;
    bit           spur_en = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] pend_data = '0;
    logic [31:0]  sv_addr = '0;
    logic [127:0] sv_wd = '0;
    logic         sv_we = 1'b0;
    logic [31:0]  log_addr [8];
    logic         log_we   [8];
    logic [127:0] log_wd   [8];

    int           cyc;
    int           guard;
    logic [511:0] wd;
    logic [511:0] wd2;

    always #5 clk = ~clk;

    l2_icache_fill_resp #(.BEAT_W(128), .ADDR_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .I_cache_req      (I_cache_req),
        .I_cache_req_op   (I_cache_req_op),
        .I_cache_req_addr (I_cache_req_addr),
        .I_cache_wr_data  (I_cache_wr_data),
        .L2_cache_ack     (L2_cache_ack),
        .I_cache_rd_data  (I_cache_rd_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Backend: decides gnt/rvalid on the falling edge; read beat i returns {32{i}} ^ key
    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (!rst_n) begin
            pend      = 1'b0;
            wait_cnt  = 0;
            prev_wait = 1'b0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                    pend       = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end else if (spur_en) begin
                mem_rvalid = 1'b1;
                mem_rdata  = JUNK;
            end
            if (mem_req === 1'b1) begin
                req_cyc++;
                if (prev_wait) begin
                    chk("hold_addr", mem_addr, sv_addr);
                    chk("hold_wdata", mem_wdata, sv_wd);
                    chk("hold_we", mem_we, sv_we);
                end
                if (gnt_cnt == dly_idx && wait_cnt < dly) begin
                    wait_cnt++;
                    prev_wait = 1'b1;
                    sv_addr   = mem_addr;
                    sv_wd     = mem_wdata;
                    sv_we     = mem_we;
                end else begin
                    mem_gnt   = 1'b1;
                    prev_wait = 1'b0;
                    wait_cnt  = 0;
                    if (gnt_cnt < 8) begin
                        log_addr[gnt_cnt] = mem_addr;
                        log_we[gnt_cnt]   = mem_we;
                        log_wd[gnt_cnt]   = mem_wdata;
                    end
                    gnt_cnt++;
                    if (mem_we !== 1'b1) begin
                        pend      = 1'b1;
                        pend_cnt  = rv_dly;
                        pend_data = {32{{2'b00, mem_addr[5:4]}}} ^ key;
                    end
                end
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    // Present a request, scramble the inputs after capture, return the ack cycle (t0+N)
    task automatic do_req(input logic op, input logic [31:0] addr, input logic [511:0] wdat, output int c);
        @(negedge clk);
        gnt_cnt          = 0;
        req_cyc          = 0;
        I_cache_req      = 1'b1;
        I_cache_req_op   = op;
        I_cache_req_addr = addr;
        I_cache_wr_data  = wdat;
        @(posedge clk); #1;
        I_cache_req_op   = ~op;
        I_cache_req_addr = 32'hDEAD_BEC0;
        I_cache_wr_data  = ~wdat;
        c = 1;
        while (L2_cache_ack !== 1'b1 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    // Requester keeps req high through the ack cycle, then drops it
    task automatic end_req(input string tag);
        @(posedge clk); #1;
        I_cache_req = 1'b0;
        chk({tag, "_ack_pulse"}, L2_cache_ack, 0);
        chk({tag, "_no_reissue"}, mem_req, 0);
        @(posedge clk); #1;
        chk({tag, "_idle"}, mem_req, 0);
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", L2_cache_ack, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rd_data", I_cache_rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // zero-wait read of 0x1000_0040
        do_req(1'b0, 32'h1000_0040, '0, cyc);
        chk("rd_ack_cycle", cyc, 9);
        chk("rd_line", I_cache_rd_data, LINE_A);
        chk("rd_req_cycles", req_cyc, 4);
        for (int i = 0; i < 4; i++) begin
            chk("rd_beat_addr", log_addr[i], 32'h1000_0040 + 32'(16 * i));
            chk("rd_beat_we", log_we[i], 0);
        end
        end_req("rd");
        chk("rd_data_holds", I_cache_rd_data, LINE_A);

        // write 0x2000_0000, beat 1 waits two cycles for gnt
        for (int i = 0; i < 4; i++) wd[i*128 +: 128] = WR_BASE | 128'(i);
        dly_idx = 1;
        dly     = 2;
        do_req(1'b1, 32'h2000_0000, wd, cyc);
        chk("wr_ack_cycle", cyc, 7);
        chk("wr_rd_data_unchanged", I_cache_rd_data, LINE_A);
        for (int i = 0; i < 4; i++) begin
            chk("wr_beat_addr", log_addr[i], 32'h2000_0000 + 32'(16 * i));
            chk("wr_beat_we", log_we[i], 1);
            chk("wr_beat_data", log_wd[i], WR_BASE | 128'(i));
        end
        end_req("wr");
        dly_idx = -1;
        dly     = 0;

        // spurious rvalid while idle
        spur_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("spur_idle_rd_data", I_cache_rd_data, LINE_A);
        chk("spur_idle_mem_req", mem_req, 0);

        // read with spurious rvalid during REQ and one extra cycle of rvalid delay per beat
        key    = '1;
        rv_dly = 1;
        do_req(1'b0, 32'h3000_0080, '0, cyc);
        chk("rdslow_ack_cycle", cyc, 13);
        chk("rdslow_line", I_cache_rd_data, LINE_B);
        chk("rdslow_beat3_addr", log_addr[3], 32'h3000_00B0);
        end_req("rdslow");
        spur_en = 1'b0;
        rv_dly  = 0;
        key     = '0;

        // reset while beat 2 response is pending
        @(negedge clk);
        gnt_cnt          = 0;
        I_cache_req      = 1'b1;
        I_cache_req_op   = 1'b0;
        I_cache_req_addr = 32'h1000_0040;
        guard = 0;
        while (gnt_cnt < 3 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rstmid_reached_beat2", gnt_cnt, 3);
        @(negedge clk);
        rst_n       = 1'b0;
        I_cache_req = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_ack", L2_cache_ack, 0);
        chk("rstmid_rd_data", I_cache_rd_data, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fresh read after reset
        do_req(1'b0, 32'h1000_0040, '0, cyc);
        chk("rdfresh_ack_cycle", cyc, 9);
        chk("rdfresh_line", I_cache_rd_data, LINE_A);
        end_req("rdfresh");

`ifdef L2_RESP_LINEBUF_EN
        // repeat read of the buffered line
        do_req(1'b0, 32'h1000_0040, '0, cyc);
        chk("lb_hit_ack_cycle", cyc, 1);
        chk("lb_hit_req_cycles", req_cyc, 0);
        chk("lb_hit_line", I_cache_rd_data, LINE_A);
        end_req("lb_hit");

        // write the buffered line, then read it back from the buffer
        for (int i = 0; i < 4; i++) wd2[i*128 +: 128] = WR2_BASE | 128'(i);
        do_req(1'b1, 32'h1000_0040, wd2, cyc);
        chk("lb_wr_ack_cycle", cyc, 5);
        chk("lb_wr_rd_data_unchanged", I_cache_rd_data, LINE_A);
        end_req("lb_wr");
        do_req(1'b0, 32'h1000_0040, '0, cyc);
        chk("lb_rd_after_wr_ack_cycle", cyc, 1);
        chk("lb_rd_after_wr_req_cycles", req_cyc, 0);
        chk("lb_rd_after_wr_line", I_cache_rd_data, wd2);
        end_req("lb_rd_after_wr");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
